// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: edge-triggered capture, FWFT valid/ready
// output, occupancy reporting and a sticky overflow flag.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clear_ovf
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              in_valid_q;
    logic              overflow_q, overflow_d;
    logic              push, pop, wr_en, drop;

    // Status flags come only from registered count, so out_ready never reaches an output.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == (ADDR_W + 1)'(DEPTH));
        out_valid = ~empty;
        count     = count_q;
        overflow  = overflow_q;
        out_data  = out_valid ? mem[rd_ptr_q] : 8'h00;
    end

    always_comb begin
        push = in_valid & ~in_valid_q;
        pop  = out_valid & out_ready;
        // When full, a simultaneous pop frees the slot the new byte lands in.
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;

        wr_ptr_d = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

        count_d = count_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Edge detector resets high so a level held across reset release is not a push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_valid_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_valid_q <= in_valid;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte-wide receive buffer sitting directly downstream of the UART receiver. It captures each received byte on the rising edge of the receiver's ready indication and buffers up to DEPTH bytes. Bytes are presented to the consumer through a first-word-fall-through valid/ready interface. It reports occupancy and keeps a sticky overflow flag.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2, minimum 2
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
in_data  input  8  received byte from UART receiver
in_valid  input  1  receiver byte-ready; a write is triggered by its 0->1 transition only
out_data  output  8  head-of-queue byte; meaningful only while out_valid=1
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head byte when out_valid & out_ready
count  output  ADDR_W+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: a byte was dropped because the FIFO was full
clear_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, out_valid=0, out_data=8'h00, overflow=0, in_valid edge-detect register=1. Storage array is not reset.
- Edge-detect register resets to 1 so that in_valid held high across reset release does not cause a spurious write.
- Push: push = in_valid & ~in_valid_q, where in_valid_q is in_valid registered one cycle. A level held high produces exactly one push. Back-to-back pushes require in_valid to drop for at least 1 cycle.
- in_data is sampled in the same cycle push is detected.
- Pop: pop = out_valid & out_ready. Pop with empty=1 is a no-op; out_ready is ignored while empty.
- Latency: a byte pushed at edge N appears on out_data with out_valid=1 after edge N (FWFT, 1 cycle). Head update after a pop is also visible 1 cycle later.
- out_data is registered or driven from mem[rd_ptr]. It must equal the oldest unpopped byte whenever out_valid=1.
- Pointers: ADDR_W bits, wrap naturally modulo DEPTH. count tracks occupancy separately: +1 on push only, -1 on pop only, unchanged on both or neither.
- Boundary rules:
  - Push & pop when empty: push accepted, pop ignored; count becomes 1.
  - Push & pop when full: both accepted; count stays DEPTH; popped byte is the old head, new byte goes to the tail.
  - Push when full without pop: byte dropped; pointers and count unchanged; overflow <= 1 on the next edge.
  - clear_ovf=1 clears overflow on the next edge. If an overflow event occurs in the same cycle as clear_ovf, set wins and overflow remains 1.
- full, empty and out_valid are derived from registered count, so they are consistent with count in every cycle.
- Reset asserted mid-operation: all contents are discarded immediately; outputs return to reset values asynchronously.
- No combinational path from out_ready to any output.

Test Plan:
- Reset, then pulse in_valid with in_data=8'hA5 -> 1 cycle later out_valid=1, out_data=8'hA5, count=1. Assert out_ready 1 cycle -> out_valid=0, empty=1, count=0.
- Hold in_valid high for 10 cycles with in_data=8'h3C -> exactly one entry stored, count=1.
- Push 16 bytes 8'h00..8'h0F with out_ready=0 -> full=1, count=16. Push 8'hFF -> dropped, overflow=1. Drain all 16 -> output order 8'h00..8'h0F; 8'hFF never appears.
- Fill to 16, then push 8'h55 in the same cycle out_ready=1 -> count stays 16, head becomes 8'h01, 8'h55 is the last byte drained.
- With overflow=1, assert clear_ovf in the same cycle as another full-drop -> overflow stays 1. Assert clear_ovf alone -> overflow=0.
- Push 40 bytes in a streaming push/pop pattern across pointer wrap -> all 40 bytes delivered in order. Assert rst=0 mid-stream with count=5 -> count=0, empty=1, out_valid=0 immediately.
